cache_tag_lru_array: RTL and testbench
======================================

// Module: cache_tag_lru_array
// PURPOSE
//  Parametrised N-way set-associative tag/metadata store, successor to the fixed 2-way x 64-set 8-bit array.
//  Holds a tag and valid bit per way and true-LRU ages per set.
//  Performs registered hit detection and victim selection, and supports a multi-cycle flush sweep.
//  Sits between the cache controller FSM and the data array; the controller uses rsp_hit_way / rsp_victim_way as the data-array way select.
// PARAMETERS
//  SETS   64  number of sets, power of 2, >=2; SET_W = $clog2(SETS) is derived locally
//  WAYS   2   associativity, power of 2, 2..8; AGE_W = $clog2(WAYS) is derived locally
//  TAG_W  8   tag width in bits
// PORTS
//  clk            in   1             rising-edge clock
//  rst            in   1             synchronous reset, active-high
//  lkp_valid      in   1             lookup request this cycle
//  lkp_set        in   SET_W         lookup set index
//  lkp_tag        in   TAG_W         lookup tag
//  fill_en        in   1             write tag into lines fill_set / fill_way
//  fill_set       in   SET_W         fill set index
//  fill_way       in   AGE_W         fill way index
//  fill_tag       in   TAG_W         fill tag
//  flush_req      in   1             one-cycle pulse: invalidate every line
//  busy           out  1             flush sweep in progress
//  rsp_valid      out  1             lookup response valid, 1 cycle after lkp_valid
//  rsp_hit        out  1             tag matched in a valid way
//  rsp_hit_way    out  AGE_W         matching way; 0 when rsp_hit=0
//  rsp_victim_way out  AGE_W         replacement candidate for the looked-up set
//  rsp_err        out  1             parity error; tied 0 without PARITY_EN
// BEHAVIOUR
//  Reset (synchronous, 1 cycle):
//    - all valid bits = 0; age[s][w] = w; tag contents are don't-care
//    - busy, rsp_valid, rsp_hit, rsp_hit_way, rsp_victim_way, rsp_err = 0
//    - rst mid-flush aborts the sweep; the reset result is identical
//  Lookup, latency 1:
//    - array is read in the cycle lkp_valid=1; rsp_* are registered; rsp_valid=0 in every cycle with no lookup
//    - a same-cycle fill to the same set is NOT visible (read-before-write)
//    - multiple valid matches cannot occur under legal use; the lowest index wins
//  Victim selection:
//    - lowest-index invalid way if one exists; otherwise the way with age == WAYS-1
//  LRU update, applied at the clock edge ending the request cycle:
//    - touched way w gets age 0; every way with age < old age[w] increments; others hold
//    - a lookup hit touches its hit way; a fill touches fill_way
//    - fill and lookup hit to the same set in one cycle: only the fill update applies
//    - fill and lookup to different sets: both updates apply
//    - a lookup miss changes no state
//  Fill:
//    - sets tag = fill_tag and valid = 1 in one cycle; overwrites a valid line silently
//  Flush FSM, states IDLE -> SWEEP -> IDLE:
//    - flush_req in IDLE: next state SWEEP; busy=1; set counter = 0
//    - SWEEP: clears valid bits and resets ages to the way index for one set per cycle
//    - after set SETS-1, return to IDLE; busy is high for exactly SETS cycles
//    - during busy: lkp_valid still produces rsp_valid with rsp_hit=0 and no LRU update
//    - during busy: fill_en and flush_req are ignored
//    - the counter wraps safely at SETS-1
// CONFIGURATION
//  PARITY_EN defined:
//    - a parity bit (XOR of tag) is stored per way and written on fill
//    - on lookup, a valid way with bad stored parity raises rsp_err=1 for that response
//    - that way is treated as a non-match (forced miss) and is the preferred victim
//  PARITY_EN undefined:
//    - no parity storage; rsp_err is tied to 0
// TESTING
//  1 Reset, SETS=64 WAYS=2, lookup set 5 tag 0x3C -> rsp_valid=1 next cycle, rsp_hit=0, rsp_victim_way=0
//  2 Fill set 5 way 1 tag 0x3C, then lookup set 5 tag 0x3C -> rsp_hit=1, rsp_hit_way=1; next lookup miss -> victim_way=0
//  3 WAYS=4: fill ways 0..3 of set 2 in order, then hit way 0 -> victim_way=1; hit way 1 -> victim_way=2
//  4 Fill set 7 and look up set 7 in the same cycle -> miss; repeat the lookup -> hit
//  5 Fill 3 sets, pulse flush_req -> busy high for exactly 64 cycles; lookups during busy -> hit=0; afterwards all miss
//  6 PARITY_EN: force a corrupt parity bit on set 9 way 0, look up the matching tag -> rsp_err=1, rsp_hit=0, victim_way=0

Source files
------------

// File: rtl/cache_tag_lru_array_if.sv
// Request/response bundle between the cache controller and the tag/LRU array.
// Signal directions are named from the array's point of view (i_ = into the array).
interface cache_tag_lru_array_if #(
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int TAG_W = 8
);
  localparam int SET_W = $clog2(SETS);
  localparam int AGE_W = $clog2(WAYS);

  logic             i_lkp_valid;
  logic [SET_W-1:0] i_lkp_set;
  logic [TAG_W-1:0] i_lkp_tag;
  logic             i_fill_en;
  logic [SET_W-1:0] i_fill_set;
  logic [AGE_W-1:0] i_fill_way;
  logic [TAG_W-1:0] i_fill_tag;
  logic             i_flush_req;
  logic             o_busy;
  logic             o_rsp_valid;
  logic             o_rsp_hit;
  logic [AGE_W-1:0] o_rsp_hit_way;
  logic [AGE_W-1:0] o_rsp_victim_way;
  logic             o_rsp_err;

  modport master (
    output i_lkp_valid, i_lkp_set, i_lkp_tag,
    output i_fill_en, i_fill_set, i_fill_way, i_fill_tag, i_flush_req,
    input  o_busy, o_rsp_valid, o_rsp_hit, o_rsp_hit_way, o_rsp_victim_way, o_rsp_err
  );

  modport slave (
    input  i_lkp_valid, i_lkp_set, i_lkp_tag,
    input  i_fill_en, i_fill_set, i_fill_way, i_fill_tag, i_flush_req,
    output o_busy, o_rsp_valid, o_rsp_hit, o_rsp_hit_way, o_rsp_victim_way, o_rsp_err
  );
endinterface

// File: rtl/cache_tag_lru_array.sv
// N-way set-associative tag/valid store with true-LRU ages, registered hit/victim lookup and flush sweep.
// Define PARITY_EN to store a per-way tag parity bit and report corrupted lines through o_rsp_err.
module cache_tag_lru_array #(
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int TAG_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  cache_tag_lru_array_if.slave bus
);
  localparam int SET_W = $clog2(SETS);
  localparam int AGE_W = $clog2(WAYS);

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  state_t           r_state;
  logic             r_busy;
  logic [SET_W-1:0] r_cnt;
  logic [WAYS-1:0]  r_valid [SETS];
  logic [AGE_W-1:0] r_age   [SETS][WAYS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
`ifdef PARITY_EN
  logic [WAYS-1:0]  r_par   [SETS];
`endif

  logic             r_rspValid;
  logic             r_rspHit;
  logic             r_rspErr;
  logic [AGE_W-1:0] r_rspHitWay;
  logic [AGE_W-1:0] r_rspVictim;

  logic [WAYS-1:0]  w_bad;
  logic             w_hit;
  logic             w_freeFound;
  logic             w_badFound;
  logic [AGE_W-1:0] w_hitWay;
  logic [AGE_W-1:0] w_freeWay;
  logic [AGE_W-1:0] w_badWay;
  logic [AGE_W-1:0] w_oldWay;
  logic [AGE_W-1:0] w_victim;
  logic             w_fillDo;
  logic             w_lkpTouch;

  // Scanning from the top way down leaves the lowest matching index as the winner.
  always_comb begin
    w_bad       = '0;
    w_hit       = 1'b0;
    w_hitWay    = '0;
    w_freeFound = 1'b0;
    w_freeWay   = '0;
    w_badFound  = 1'b0;
    w_badWay    = '0;
    w_oldWay    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
`ifdef PARITY_EN
      w_bad[w] = r_valid[bus.i_lkp_set][w] &&
                 ((^r_tag[bus.i_lkp_set][w]) != r_par[bus.i_lkp_set][w]);
`endif
      if (r_valid[bus.i_lkp_set][w] && !w_bad[w] &&
          (r_tag[bus.i_lkp_set][w] == bus.i_lkp_tag)) begin
        w_hit    = 1'b1;
        w_hitWay = AGE_W'(w);
      end
      if (!r_valid[bus.i_lkp_set][w]) begin
        w_freeFound = 1'b1;
        w_freeWay   = AGE_W'(w);
      end
      if (w_bad[w]) begin
        w_badFound = 1'b1;
        w_badWay   = AGE_W'(w);
      end
      if (r_age[bus.i_lkp_set][w] == AGE_W'(WAYS - 1)) begin
        w_oldWay = AGE_W'(w);
      end
    end
    w_victim = w_badFound ? w_badWay : (w_freeFound ? w_freeWay : w_oldWay);
  end

  // A fill to the same set as a hitting lookup wins the LRU update outright.
  assign w_fillDo   = bus.i_fill_en && !r_busy;
  assign w_lkpTouch = bus.i_lkp_valid && !r_busy && w_hit &&
                      !(w_fillDo && (bus.i_fill_set == bus.i_lkp_set));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
      r_rspValid  <= 1'b0;
      r_rspHit    <= 1'b0;
      r_rspHitWay <= '0;
      r_rspVictim <= '0;
      r_rspErr    <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= AGE_W'(w);
      end
    end else begin
      r_rspValid <= bus.i_lkp_valid;
      if (bus.i_lkp_valid) begin
        r_rspHit    <= w_hit && !r_busy;
        r_rspHitWay <= (w_hit && !r_busy) ? w_hitWay : '0;
        r_rspVictim <= w_victim;
        r_rspErr    <= |w_bad;
      end else begin
        r_rspHit    <= 1'b0;
        r_rspHitWay <= '0;
        r_rspVictim <= '0;
        r_rspErr    <= 1'b0;
      end

      if (w_lkpTouch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == w_hitWay)
            r_age[bus.i_lkp_set][w] <= '0;
          else if (r_age[bus.i_lkp_set][w] < r_age[bus.i_lkp_set][w_hitWay])
            r_age[bus.i_lkp_set][w] <= r_age[bus.i_lkp_set][w] + AGE_W'(1);
        end
      end

      if (w_fillDo) begin
        r_valid[bus.i_fill_set][bus.i_fill_way] <= 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == bus.i_fill_way)
            r_age[bus.i_fill_set][w] <= '0;
          else if (r_age[bus.i_fill_set][w] < r_age[bus.i_fill_set][bus.i_fill_way])
            r_age[bus.i_fill_set][w] <= r_age[bus.i_fill_set][w] + AGE_W'(1);
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.i_flush_req) begin
            r_state <= ST_SWEEP;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ST_SWEEP: begin
          r_valid[r_cnt] <= '0;
          for (int w = 0; w < WAYS; w++) r_age[r_cnt][w] <= AGE_W'(w);
          r_cnt <= r_cnt + SET_W'(1);
          if (r_cnt == SET_W'(SETS - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Tag payload needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (!rst && w_fillDo) begin
      r_tag[bus.i_fill_set][bus.i_fill_way] <= bus.i_fill_tag;
`ifdef PARITY_EN
      r_par[bus.i_fill_set][bus.i_fill_way] <= ^bus.i_fill_tag;
`endif
    end
  end

  assign bus.o_busy           = r_busy;
  assign bus.o_rsp_valid      = r_rspValid;
  assign bus.o_rsp_hit        = r_rspHit;
  assign bus.o_rsp_hit_way    = r_rspHitWay;
  assign bus.o_rsp_victim_way = r_rspVictim;
`ifdef PARITY_EN
  assign bus.o_rsp_err        = r_rspErr;
`else
  assign bus.o_rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_cache_tag_lru_array.sv
// Directed self-checking bench for cache_tag_lru_array: a 2-way and a 4-way instance share one clock.
// Expected values are hand-derived from the LRU age rules; parity checks run only with PARITY_EN.
module tb_cache_tag_lru_array;
  logic clk = 1'b0;
  logic rst;
  int   nAssert = 0;
  int   nFail   = 0;
  int   n;

  always #5 clk = ~clk;

  cache_tag_lru_array_if #(.SETS(64), .WAYS(2), .TAG_W(8)) if2 ();
  cache_tag_lru_array_if #(.SETS(64), .WAYS(4), .TAG_W(8)) if4 ();

  cache_tag_lru_array #(.SETS(64), .WAYS(2), .TAG_W(8)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  cache_tag_lru_array #(.SETS(64), .WAYS(4), .TAG_W(8)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    nAssert++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  // Drives one request cycle on the 2-way instance, then returns inputs to idle.
  task automatic applyStimulus2(input logic lkp, input logic [5:0] set, input logic [7:0] tag,
                                input logic fill, input logic [5:0] fset, input logic fway,
                                input logic [7:0] ftag, input logic flush);
    if2.i_lkp_valid = lkp;  if2.i_lkp_set  = set;  if2.i_lkp_tag  = tag;
    if2.i_fill_en   = fill; if2.i_fill_set = fset; if2.i_fill_way = fway; if2.i_fill_tag = ftag;
    if2.i_flush_req = flush;
    step();
    if2.i_lkp_valid = 1'b0; if2.i_fill_en = 1'b0; if2.i_flush_req = 1'b0;
  endtask

  task automatic applyStimulus4(input logic lkp, input logic [5:0] set, input logic [7:0] tag,
                                input logic fill, input logic [5:0] fset, input logic [1:0] fway,
                                input logic [7:0] ftag);
    if4.i_lkp_valid = lkp;  if4.i_lkp_set  = set;  if4.i_lkp_tag  = tag;
    if4.i_fill_en   = fill; if4.i_fill_set = fset; if4.i_fill_way = fway; if4.i_fill_tag = ftag;
    if4.i_flush_req = 1'b0;
    step();
    if4.i_lkp_valid = 1'b0; if4.i_fill_en = 1'b0;
  endtask

  task automatic checkRsp2(input string name, input logic v, input logic h, input logic hw, input logic vic);
    checkOutput({name, ".valid"},  32'(if2.o_rsp_valid),      32'(v));
    checkOutput({name, ".hit"},    32'(if2.o_rsp_hit),        32'(h));
    checkOutput({name, ".hitWay"}, 32'(if2.o_rsp_hit_way),    32'(hw));
    checkOutput({name, ".victim"}, 32'(if2.o_rsp_victim_way), 32'(vic));
    checkOutput({name, ".err"},    32'(if2.o_rsp_err),        32'(0));
  endtask

  task automatic checkRsp4(input string name, input logic h, input logic [1:0] hw, input logic [1:0] vic);
    checkOutput({name, ".valid"},  32'(if4.o_rsp_valid),      32'(1));
    checkOutput({name, ".hit"},    32'(if4.o_rsp_hit),        32'(h));
    checkOutput({name, ".hitWay"}, 32'(if4.o_rsp_hit_way),    32'(hw));
    checkOutput({name, ".victim"}, 32'(if4.o_rsp_victim_way), 32'(vic));
  endtask

  initial begin
    rst = 1'b1;
    if2.i_lkp_valid = 1'b0; if2.i_lkp_set = '0; if2.i_lkp_tag = '0;
    if2.i_fill_en = 1'b0; if2.i_fill_set = '0; if2.i_fill_way = '0; if2.i_fill_tag = '0;
    if2.i_flush_req = 1'b0;
    if4.i_lkp_valid = 1'b0; if4.i_lkp_set = '0; if4.i_lkp_tag = '0;
    if4.i_fill_en = 1'b0; if4.i_fill_set = '0; if4.i_fill_way = '0; if4.i_fill_tag = '0;
    if4.i_flush_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    checkOutput("reset.busy2", 32'(if2.o_busy), 32'(0));
    checkOutput("reset.busy4", 32'(if4.o_busy), 32'(0));
    checkRsp2("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Lookup into an empty set
    applyStimulus2(1, 6'd5, 8'h3C, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("t1.emptyMiss", 1, 0, 0, 0);
    applyStimulus2(0, 6'd5, 8'h3C, 0, 6'd0, 0, 8'h00, 0);
    checkOutput("t1.idleValid", 32'(if2.o_rsp_valid), 32'(0));

    // Fill and hit; second way then LRU ordering
    applyStimulus2(0, 6'd0, 8'h00, 1, 6'd5, 1, 8'h3C, 0);
    applyStimulus2(1, 6'd5, 8'h3C, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("t2.hitWay1", 1, 1, 1, 0);
    applyStimulus2(1, 6'd5, 8'h11, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("t2.missInvalidVictim", 1, 0, 0, 0);
    applyStimulus2(0, 6'd0, 8'h00, 1, 6'd5, 0, 8'h22, 0);
    applyStimulus2(1, 6'd5, 8'h11, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("t2.missLruWay1", 1, 0, 0, 1);
    applyStimulus2(1, 6'd5, 8'h3C, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("t2.hitPreAges", 1, 1, 1, 1);
    applyStimulus2(1, 6'd5, 8'h99, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("t2.missLruWay0", 1, 0, 0, 0);

    // Hit and fill to the same set: only the fill touches LRU
    applyStimulus2(1, 6'd5, 8'h3C, 1, 6'd5, 0, 8'h66, 0);
    checkRsp2("sameSet.rsp", 1, 1, 1, 0);
    applyStimulus2(1, 6'd5, 8'h77, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("sameSet.victim", 1, 0, 0, 1);
    applyStimulus2(1, 6'd5, 8'h66, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("sameSet.fillTag", 1, 1, 0, 1);

    // Read-before-write on a same-cycle fill
    applyStimulus2(1, 6'd7, 8'h55, 1, 6'd7, 0, 8'h55, 0);
    checkRsp2("t4.sameCycleMiss", 1, 0, 0, 0);
    applyStimulus2(1, 6'd7, 8'h55, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("t4.repeatHit", 1, 1, 0, 1);

    // Hit and fill to different sets: both update
    applyStimulus2(1, 6'd5, 8'h3C, 1, 6'd7, 1, 8'h56, 0);
    checkRsp2("diffSet.rsp", 1, 1, 1, 1);
    applyStimulus2(1, 6'd5, 8'h01, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("diffSet.set5Victim", 1, 0, 0, 0);
    applyStimulus2(1, 6'd7, 8'h01, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("diffSet.set7Victim", 1, 0, 0, 0);
    applyStimulus2(1, 6'd7, 8'h56, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("diffSet.set7Hit", 1, 1, 1, 0);

`ifdef PARITY_EN
    applyStimulus2(0, 6'd0, 8'h00, 1, 6'd9, 0, 8'h12, 0);
    force dut2.r_par[9] = 2'b01;
    applyStimulus2(1, 6'd9, 8'h12, 0, 6'd0, 0, 8'h00, 0);
    checkOutput("t6.err",    32'(if2.o_rsp_err),        32'(1));
    checkOutput("t6.hit",    32'(if2.o_rsp_hit),        32'(0));
    checkOutput("t6.victim", 32'(if2.o_rsp_victim_way), 32'(0));
    release dut2.r_par[9];
`endif

    // Flush sweep: busy for exactly 64 cycles; fill and flush_req ignored meanwhile
    applyStimulus2(0, 6'd0, 8'h00, 1, 6'd9, 1, 8'h90, 1);
    checkOutput("t5.busyRise", 32'(if2.o_busy), 32'(1));
    n = 0;
    while (if2.o_busy === 1'b1 && n < 200) begin
      n++;
      applyStimulus2(1, 6'd5, 8'h3C, (n == 10), 6'd5, 0, 8'h3C, (n == 10));
      checkOutput("t5.busyValid", 32'(if2.o_rsp_valid), 32'(1));
      checkOutput("t5.busyHit",   32'(if2.o_rsp_hit),   32'(0));
    end
    checkOutput("t5.busyCycles", 32'(n), 32'(64));
    applyStimulus2(1, 6'd5, 8'h3C, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("t5.afterSet5", 1, 0, 0, 0);
    applyStimulus2(1, 6'd7, 8'h56, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("t5.afterSet7", 1, 0, 0, 0);
    applyStimulus2(1, 6'd9, 8'h90, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("t5.afterSet9", 1, 0, 0, 0);

    // Reset in the middle of a sweep
    applyStimulus2(0, 6'd0, 8'h00, 0, 6'd0, 0, 8'h00, 1);
    applyStimulus2(0, 6'd0, 8'h00, 0, 6'd0, 0, 8'h00, 0);
    applyStimulus2(0, 6'd0, 8'h00, 0, 6'd0, 0, 8'h00, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midReset.busy", 32'(if2.o_busy), 32'(0));
    applyStimulus2(0, 6'd0, 8'h00, 1, 6'd3, 1, 8'h33, 0);
    applyStimulus2(1, 6'd3, 8'h33, 0, 6'd0, 0, 8'h00, 0);
    checkRsp2("midReset.fillHit", 1, 1, 1, 0);
    checkOutput("midReset.busyStill", 32'(if2.o_busy), 32'(0));

    // 4-way true-LRU ordering
    applyStimulus4(0, 6'd0, 8'h00, 1, 6'd2, 2'd0, 8'hA0);
    applyStimulus4(0, 6'd0, 8'h00, 1, 6'd2, 2'd1, 8'hA1);
    applyStimulus4(0, 6'd0, 8'h00, 1, 6'd2, 2'd2, 8'hA2);
    applyStimulus4(0, 6'd0, 8'h00, 1, 6'd2, 2'd3, 8'hA3);
    applyStimulus4(1, 6'd2, 8'hFF, 0, 6'd0, 2'd0, 8'h00);
    checkRsp4("t3.fullMiss", 0, 2'd0, 2'd0);
    applyStimulus4(1, 6'd2, 8'hA0, 0, 6'd0, 2'd0, 8'h00);
    checkRsp4("t3.hit0", 1, 2'd0, 2'd0);
    applyStimulus4(1, 6'd2, 8'hFF, 0, 6'd0, 2'd0, 8'h00);
    checkRsp4("t3.victimAfterHit0", 0, 2'd0, 2'd1);
    applyStimulus4(1, 6'd2, 8'hA1, 0, 6'd0, 2'd0, 8'h00);
    checkRsp4("t3.hit1", 1, 2'd1, 2'd1);
    applyStimulus4(1, 6'd2, 8'hFF, 0, 6'd0, 2'd0, 8'h00);
    checkRsp4("t3.victimAfterHit1", 0, 2'd0, 2'd2);
    applyStimulus4(1, 6'd2, 8'hA3, 0, 6'd0, 2'd0, 8'h00);
    checkRsp4("t3.hit3", 1, 2'd3, 2'd2);
    applyStimulus4(1, 6'd2, 8'hA2, 0, 6'd0, 2'd0, 8'h00);
    checkRsp4("t3.hit2", 1, 2'd2, 2'd2);
    applyStimulus4(1, 6'd2, 8'hFF, 0, 6'd0, 2'd0, 8'h00);
    checkRsp4("t3.victimAfterHit2", 0, 2'd0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
